// File: rtl/s_data_deframer_pkg.sv
// Router link framing constants shared by the capture and transmit ends.
// Sync word precedes a MSB-first payload on an idle-low serial line.
package router_pkg;
    localparam int PAYLOAD_W = 55;
    localparam int SYNC_W    = 6;
    localparam logic [SYNC_W-1:0] SYNC_PATTERN = 6'b011111;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;
endpackage

// File: rtl/s_data_deframer_if.sv
// Packet handoff from the deframer to the router core: valid/ready with a registered payload.
interface s_data_deframer_if #(
    parameter int PAYLOAD_W = router_pkg::PAYLOAD_W
);
    logic                 Pkt_Valid;
    logic                 Pkt_Ready;
    logic [PAYLOAD_W-1:0] Pkt_Data;

    modport master (output Pkt_Valid, output Pkt_Data, input Pkt_Ready);
    modport slave  (input Pkt_Valid, input Pkt_Data, output Pkt_Ready);
endinterface

// File: rtl/s_data_deframer_out_reg.sv
// One-entry packet holding register; latency 1 cycle from load to Pkt_Valid.
// Backpressure: a load into an occupied, unconsumed slot is dropped and flagged by a one-cycle overrun pulse.
module deframe_out_reg #(
    parameter int PAYLOAD_W = router_pkg::PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_vld,
    input  logic [PAYLOAD_W-1:0] load_dat,
    s_data_deframer_if.master    pkt,
    output logic                 overrun,
    output logic [7:0]           frame_cnt
);
    logic slot_free;

    // A consume on the same edge frees the slot for a new load.
    assign slot_free = !pkt.Pkt_Valid || pkt.Pkt_Ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt.Pkt_Valid <= 1'b0;
            pkt.Pkt_Data  <= '0;
            overrun       <= 1'b0;
            frame_cnt     <= 8'd0;
        end else begin
            overrun <= load_vld && !slot_free;
            if (load_vld && slot_free) begin
                pkt.Pkt_Valid <= 1'b1;
                pkt.Pkt_Data  <= load_dat;
                frame_cnt     <= frame_cnt + 8'd1;
            end else if (pkt.Pkt_Valid && pkt.Pkt_Ready) begin
                pkt.Pkt_Valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/s_data_deframer.sv
// Serial deframer: hunts the sync word on S_Data, shifts in the MSB-first payload, hands it off.
// Latency: Pkt_Valid one cycle after the last payload bit; a full slot drops the frame with Overrun.
module s_data_deframer import router_pkg::*; #(
    parameter int                SYNC_W       = router_pkg::SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = router_pkg::SYNC_PATTERN,
    parameter int                PAYLOAD_W    = router_pkg::PAYLOAD_W
) (
    input  logic              Clk_S,
    input  logic              Rst,
    input  logic              S_Data,
    s_data_deframer_if.master pkt,
    output logic              Busy,
    output logic              Overrun,
    output logic [7:0]        Frame_Cnt
);
    localparam int CNT_W = $clog2(PAYLOAD_W);

    state_t               state, state_nxt;
    logic [SYNC_W-1:0]    sync_sr, sync_shift;
    logic [PAYLOAD_W-1:0] payload_sr, payload_shift;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 sync_hit, frame_done;

    assign sync_shift    = {sync_sr[SYNC_W-2:0], S_Data};
    assign payload_shift = {payload_sr[PAYLOAD_W-2:0], S_Data};

    always_ff @(posedge Clk_S or posedge Rst) begin
        if (Rst) state <= HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:    if (sync_hit)   state_nxt = PAYLOAD;
            PAYLOAD: if (frame_done) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    always_comb begin
        sync_hit   = 1'b0;
        frame_done = 1'b0;
        case (state)
            HUNT:    sync_hit   = (sync_shift == SYNC_PATTERN);
            PAYLOAD: frame_done = (bit_cnt == CNT_W'(PAYLOAD_W - 1));
            default: ;
        endcase
    end

    // Clearing the sync shifter on frame exit keeps payload bits from ever completing a sync.
    always_ff @(posedge Clk_S or posedge Rst) begin
        if (Rst) begin
            sync_sr    <= '0;
            payload_sr <= '0;
            bit_cnt    <= '0;
            Busy       <= 1'b0;
        end else begin
            Busy <= (state_nxt == PAYLOAD);
            if (state == HUNT) begin
                sync_sr <= sync_shift;
                bit_cnt <= '0;
            end else begin
                payload_sr <= payload_shift;
                bit_cnt    <= bit_cnt + 1'b1;
                if (frame_done) sync_sr <= '0;
            end
        end
    end

    deframe_out_reg #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_out_reg (
        .clk       (Clk_S),
        .rst       (Rst),
        .load_vld  (frame_done),
        .load_dat  (payload_shift),
        .pkt       (pkt),
        .overrun   (Overrun),
        .frame_cnt (Frame_Cnt)
    );
endmodule

// File: tb/tb_s_data_deframer.sv
// Directed bench for s_data_deframer: framing, overrun, simultaneous handoff, reset and counter wrap.
module tb_s_data_deframer;
    import router_pkg::*;

    logic       Clk_S = 1'b0;
    logic       Rst;
    logic       S_Data;
    logic       Busy;
    logic       Overrun;
    logic [7:0] Frame_Cnt;

    int errors   = 0;
    int checks   = 0;
    int ovr_seen = 0;

    s_data_deframer_if pkt ();

    s_data_deframer dut (
        .Clk_S     (Clk_S),
        .Rst       (Rst),
        .S_Data    (S_Data),
        .pkt       (pkt),
        .Busy      (Busy),
        .Overrun   (Overrun),
        .Frame_Cnt (Frame_Cnt)
    );

    always #5 Clk_S = ~Clk_S;

    always @(negedge Clk_S) if (Overrun === 1'b1) ovr_seen++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one line bit at the falling edge; return just after the sampling edge.
    task automatic tick(input logic b, input logic rdy);
        @(negedge Clk_S);
        S_Data        = b;
        pkt.Pkt_Ready = rdy;
        @(posedge Clk_S);
        #1;
    endtask

    task automatic send_sync(input logic rdy);
        logic [5:0] sp;
        sp = SYNC_PATTERN;
        for (int i = 5; i >= 0; i--) tick(sp[i], rdy);
    endtask

    task automatic send_payload(input logic [54:0] p, input int nbits, input logic rdy, input logic rdy_last);
        for (int i = 0; i < nbits; i++) tick(p[54-i], (i == 54) ? rdy_last : rdy);
    endtask

    task automatic do_reset();
        Rst           = 1'b1;
        S_Data        = 1'b0;
        pkt.Pkt_Ready = 1'b0;
        repeat (2) @(negedge Clk_S);
        Rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [54:0] p;
        int o0;

        // NACK frame: reset values, latency and one-cycle valid
        do_reset();
        chk("rst_valid", 64'(pkt.Pkt_Valid), 64'd0);
        chk("rst_data",  64'(pkt.Pkt_Data),  64'd0);
        chk("rst_busy",  64'(Busy),          64'd0);
        chk("rst_ovr",   64'(Overrun),       64'd0);
        chk("rst_cnt",   64'(Frame_Cnt),     64'd0);
        repeat (4) tick(1'b0, 1'b1);
        chk("idle_busy", 64'(Busy), 64'd0);
        send_sync(1'b1);
        chk("sync_busy", 64'(Busy), 64'd1);
        send_payload(55'h3F_FFFF_FFFF_FFFF, 54, 1'b1, 1'b1);
        chk("nack_e60_valid", 64'(pkt.Pkt_Valid), 64'd0);
        chk("nack_e60_busy",  64'(Busy),          64'd1);
        tick(1'b1, 1'b1);
        chk("nack_e61_valid", 64'(pkt.Pkt_Valid), 64'd1);
        chk("nack_data",      64'(pkt.Pkt_Data),  64'h3F_FFFF_FFFF_FFFF);
        chk("nack_cnt",       64'(Frame_Cnt),     64'd1);
        chk("nack_busy_fall", 64'(Busy),          64'd0);
        tick(1'b0, 1'b1);
        chk("nack_valid_1cyc", 64'(pkt.Pkt_Valid), 64'd0);

        // Payload containing the sync pattern, two frames back-to-back
        do_reset();
        send_sync(1'b1);
        send_payload(55'h1F_0000_0000_0000, 55, 1'b1, 1'b1);
        chk("sip1_valid", 64'(pkt.Pkt_Valid), 64'd1);
        chk("sip1_data",  64'(pkt.Pkt_Data),  64'h1F_0000_0000_0000);
        send_sync(1'b1);
        send_payload(55'h1F_0000_0000_0000, 55, 1'b1, 1'b1);
        chk("sip2_valid", 64'(pkt.Pkt_Valid), 64'd1);
        chk("sip2_data",  64'(pkt.Pkt_Data),  64'h1F_0000_0000_0000);
        chk("sip2_cnt",   64'(Frame_Cnt),     64'd2);

        // Overrun with Pkt_Ready held low
        do_reset();
        send_sync(1'b0);
        send_payload(55'h1, 55, 1'b0, 1'b0);
        chk("ovr_a_valid", 64'(pkt.Pkt_Valid), 64'd1);
        chk("ovr_a_data",  64'(pkt.Pkt_Data),  64'h1);
        chk("ovr_a_pulse", 64'(Overrun),       64'd0);
        send_sync(1'b0);
        send_payload(55'h2, 55, 1'b0, 1'b0);
        chk("ovr_b_pulse", 64'(Overrun),       64'd1);
        chk("ovr_b_data",  64'(pkt.Pkt_Data),  64'h1);
        chk("ovr_b_cnt",   64'(Frame_Cnt),     64'd1);
        tick(1'b0, 1'b0);
        chk("ovr_pulse_end", 64'(Overrun),       64'd0);
        chk("ovr_hold",      64'(pkt.Pkt_Valid), 64'd1);
        tick(1'b0, 1'b1);
        chk("ovr_consume",   64'(pkt.Pkt_Valid), 64'd0);
        chk("ovr_data_kept", 64'(pkt.Pkt_Data),  64'h1);

        // Consume and complete on the same edge
        do_reset();
        send_sync(1'b0);
        send_payload(55'h1, 55, 1'b0, 1'b0);
        send_sync(1'b0);
        send_payload(55'h2, 55, 1'b0, 1'b1);
        chk("sim_data",  64'(pkt.Pkt_Data),  64'h2);
        chk("sim_valid", 64'(pkt.Pkt_Valid), 64'd1);
        chk("sim_ovr",   64'(Overrun),       64'd0);
        chk("sim_cnt",   64'(Frame_Cnt),     64'd2);

        // Reset in the middle of a frame, then a clean frame
        do_reset();
        send_sync(1'b0);
        send_payload(55'h7, 55, 1'b0, 1'b0);
        send_sync(1'b0);
        send_payload(55'h7FFF_FFFF_FFFF_FF, 30, 1'b0, 1'b0);
        chk("mid_busy", 64'(Busy), 64'd1);
        #2 Rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(pkt.Pkt_Valid), 64'd0);
        chk("mid_rst_data",  64'(pkt.Pkt_Data),  64'd0);
        chk("mid_rst_busy",  64'(Busy),          64'd0);
        chk("mid_rst_cnt",   64'(Frame_Cnt),     64'd0);
        chk("mid_rst_ovr",   64'(Overrun),       64'd0);
        @(negedge Clk_S);
        Rst = 1'b0;
        send_sync(1'b1);
        send_payload(55'h55_5555_5555_5555, 55, 1'b1, 1'b1);
        chk("post_rst_data",  64'(pkt.Pkt_Data),  64'h55_5555_5555_5555);
        chk("post_rst_valid", 64'(pkt.Pkt_Valid), 64'd1);
        chk("post_rst_cnt",   64'(Frame_Cnt),     64'd1);

        // Frame counter wrap after 256 deliveries
        do_reset();
        o0 = ovr_seen;
        p  = '0;
        for (int f = 1; f <= 256; f++) begin
            p = {23'h0, 32'(f) * 32'h9E37_79B9};
            send_sync(1'b1);
            send_payload(p, 55, 1'b1, 1'b1);
            if (f == 1)   chk("wrap_cnt1",   64'(Frame_Cnt), 64'd1);
            if (f == 255) chk("wrap_cnt255", 64'(Frame_Cnt), 64'd255);
        end
        chk("wrap_cnt0",  64'(Frame_Cnt),       64'd0);
        chk("wrap_data",  64'(pkt.Pkt_Data),    64'(p));
        chk("wrap_noovr", 64'(ovr_seen - o0),   64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
